// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_pipe
// Description : Pipelined bitwise-logic unit (XOR/AND/OR/XNOR/NAND/NOR/NOT/ANDN)
//               with valid/ready flow control, zero and illegal-op flags.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_pipe #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam logic [3:0] c_op_xor  = 4'd6;
  localparam logic [3:0] c_op_and  = 4'd7;
  localparam logic [3:0] c_op_or   = 4'd8;
  localparam logic [3:0] c_op_xnor = 4'd9;
  localparam logic [3:0] c_op_nand = 4'd10;
  localparam logic [3:0] c_op_nor  = 4'd11;
  localparam logic [3:0] c_op_not  = 4'd12;
  localparam logic [3:0] c_op_andn = 4'd13;

  logic [WIDTH-1:0] w_res;
  logic             w_ill;
  logic             w_stall;

  logic [LATENCY-1:0] r_valid;
  logic [LATENCY-1:0] r_ill;
  logic [WIDTH-1:0]   r_res [LATENCY];

  always_comb begin
    w_res = '0;
    w_ill = 1'b0;
    case (operation)
      c_op_xor:  w_res = a ^ b;
      c_op_and:  w_res = a & b;
      c_op_or:   w_res = a | b;
      c_op_xnor: w_res = ~(a ^ b);
      c_op_nand: w_res = ~(a & b);
      c_op_nor:  w_res = ~(a | b);
      c_op_not:  w_res = ~a;
      c_op_andn: w_res = a & ~b;
      default:   w_ill = 1'b1;
    endcase
  end

  // A full output stage that is not being taken freezes the whole pipe.
  assign w_stall  = r_valid[LATENCY-1] && !out_ready;
  assign in_ready = !w_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_ill   <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_res[i] <= '0;
      end
    end else if (!w_stall) begin
      r_valid[0] <= in_valid;
      r_ill[0]   <= in_valid && w_ill;
      r_res[0]   <= in_valid ? w_res : '0;
      for (int i = 1; i < LATENCY; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_ill[i]   <= r_ill[i-1];
        r_res[i]   <= r_res[i-1];
      end
    end
  end

  // Bubbles always carry zero data, so the last stage needs no output gating.
  assign out_valid = r_valid[LATENCY-1];
  assign result    = r_res[LATENCY-1];
  assign illegal   = r_ill[LATENCY-1];
  assign zero      = r_valid[LATENCY-1] && (r_res[LATENCY-1] == '0);

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_unit_pipe
// Description : Self-checking bench for logic_unit_pipe; five parameter corners
//               share one stimulus stream and a timestamp-queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_unit_pipe;

  localparam int c_ninst = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] a;
  logic [63:0] b;
  logic [3:0]  operation;
  logic        out_ready;

  logic [c_ninst-1:0] rdy, ov, zr, il;
  logic [31:0] res0;
  logic [0:0]  res1, res2;
  logic [63:0] res3, res4;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: per instance, in-flight beats with the number of
  // non-stalled edges each has seen since acceptance.
  logic [63:0] m_res [c_ninst][8];
  logic        m_ill [c_ninst][8];
  int          m_cnt [c_ninst][8];
  int          m_n   [c_ninst];

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(32), .LATENCY(2)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .a(a[31:0]), .b(b[31:0]), .operation(operation), .out_valid(ov[0]),
    .out_ready(out_ready), .result(res0), .zero(zr[0]), .illegal(il[0]));
  logic_unit_pipe #(.WIDTH(1), .LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .a(a[0:0]), .b(b[0:0]), .operation(operation), .out_valid(ov[1]),
    .out_ready(out_ready), .result(res1), .zero(zr[1]), .illegal(il[1]));
  logic_unit_pipe #(.WIDTH(1), .LATENCY(4)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
    .a(a[0:0]), .b(b[0:0]), .operation(operation), .out_valid(ov[2]),
    .out_ready(out_ready), .result(res2), .zero(zr[2]), .illegal(il[2]));
  logic_unit_pipe #(.WIDTH(64), .LATENCY(1)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[3]),
    .a(a), .b(b), .operation(operation), .out_valid(ov[3]),
    .out_ready(out_ready), .result(res3), .zero(zr[3]), .illegal(il[3]));
  logic_unit_pipe #(.WIDTH(64), .LATENCY(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[4]),
    .a(a), .b(b), .operation(operation), .out_valid(ov[4]),
    .out_ready(out_ready), .result(res4), .zero(zr[4]), .illegal(il[4]));

  function automatic int lat_of(input int k);
    case (k)
      0:       return 2;
      1, 3:    return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [63:0] mask_of(input int k);
    case (k)
      0:       return 64'h0000_0000_FFFF_FFFF;
      1, 2:    return 64'h1;
      default: return '1;
    endcase
  endfunction

  function automatic logic [63:0] res_of(input int k);
    case (k)
      0:       return {32'h0, res0};
      1:       return {63'h0, res1};
      2:       return {63'h0, res2};
      3:       return res3;
      default: return res4;
    endcase
  endfunction

  // Operation table straight from the op-code list; returns {illegal, result}.
  function automatic logic [64:0] ref_op(input logic [3:0] op, input logic [63:0] x,
                                         input logic [63:0] y);
    case (op)
      4'd6:    return {1'b0, x ^ y};
      4'd7:    return {1'b0, x & y};
      4'd8:    return {1'b0, x | y};
      4'd9:    return {1'b0, ~(x ^ y)};
      4'd10:   return {1'b0, ~(x & y)};
      4'd11:   return {1'b0, ~(x | y)};
      4'd12:   return {1'b0, ~x};
      4'd13:   return {1'b0, x & ~y};
      default: return {1'b1, 64'h0};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_ov(input int k);
    return (m_n[k] > 0) && (m_cnt[k][0] == lat_of(k));
  endfunction

  // One clock: check in_ready, advance the model, take the edge, check outputs.
  task automatic step();
    logic        mv;
    logic [64:0] r;
    #1;
    for (int k = 0; k < c_ninst; k++) begin
      if (!rst_n) m_n[k] = 0;
      mv = model_ov(k);
      chk($sformatf("u%0d_in_ready", k), {63'h0, rdy[k]}, {63'h0, !(mv && !out_ready)});
      if (rst_n && !(mv && !out_ready)) begin
        if (mv) begin
          for (int i = 1; i < m_n[k]; i++) begin
            m_res[k][i-1] = m_res[k][i];
            m_ill[k][i-1] = m_ill[k][i];
            m_cnt[k][i-1] = m_cnt[k][i];
          end
          m_n[k]--;
        end
        for (int i = 0; i < m_n[k]; i++) m_cnt[k][i]++;
        if (in_valid) begin
          r = ref_op(operation, a, b);
          m_res[k][m_n[k]] = r[63:0] & mask_of(k);
          m_ill[k][m_n[k]] = r[64];
          m_cnt[k][m_n[k]] = 1;
          m_n[k]++;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < c_ninst; k++) begin
      mv = model_ov(k);
      chk($sformatf("u%0d_out_valid", k), {63'h0, ov[k]}, {63'h0, mv});
      chk($sformatf("u%0d_result", k), res_of(k), mv ? m_res[k][0] : 64'h0);
      chk($sformatf("u%0d_zero", k), {63'h0, zr[k]}, {63'h0, mv && (m_res[k][0] == 64'h0)});
      chk($sformatf("u%0d_illegal", k), {63'h0, il[k]}, {63'h0, mv && m_ill[k][0]});
    end
  endtask

  // Single beat on u0: not visible after the accept edge, visible one edge later.
  task automatic directed(input string tag, input logic [3:0] op, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_res,
                          input logic exp_ill, input logic exp_zero);
    in_valid = 1'b1; operation = op; a = {32'h0, x}; b = {32'h0, y};
    step();
    chk({tag, "_early"}, {63'h0, ov[0]}, 64'h0);
    in_valid = 1'b0;
    step();
    chk({tag, "_valid"}, {63'h0, ov[0]}, 64'h1);
    chk({tag, "_res"}, {32'h0, res0}, {32'h0, exp_res});
    chk({tag, "_ill"}, {63'h0, il[0]}, {63'h0, exp_ill});
    chk({tag, "_zero"}, {63'h0, zr[0]}, {63'h0, exp_zero});
    step();
    step();
  endtask

  initial begin
    for (int k = 0; k < c_ninst; k++) m_n[k] = 0;
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    operation = 4'd6; a = 64'h1234; b = 64'h5678;

    // Reset held with in_valid asserted
    repeat (3) step();
    chk("rst_out_valid", {63'h0, ov[0]}, 64'h0);
    chk("rst_result", {32'h0, res0}, 64'h0);
    chk("rst_in_ready", {63'h0, rdy[0]}, 64'h1);
    rst_n = 1'b1; in_valid = 1'b0;
    step();

    // Op sweep and illegal/zero flags
    directed("op6",  4'd6,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1'b0, 1'b0);
    directed("op7",  4'd7,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1'b0);
    directed("op8",  4'd8,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFFF0_FFFF, 1'b0, 1'b0);
    directed("op12", 4'd12, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h0F0F_EDCB, 1'b0, 1'b0);
    directed("op13", 4'd13, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hF000_0000, 1'b0, 1'b0);
    directed("op2",  4'd2,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h0,         1'b1, 1'b1);
    directed("xz",   4'd6,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0,         1'b0, 1'b1);

    // Back-to-back 8 beats, then 3 cycles of backpressure mid-stream
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; operation = 4'(6 + i); a = {$urandom, $urandom}; b = {$urandom, $urandom};
      step();
    end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      operation = 4'd9; a = {$urandom, $urandom};
      step();
      chk("bp_in_ready", {63'h0, rdy[0]}, 64'h0);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    repeat (6) step();

    // Mid-stream reset with 2 beats in flight
    in_valid = 1'b1; operation = 4'd8; a = 64'hFF; b = 64'h1;
    step(); step();
    in_valid = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_drop_valid", {63'h0, ov[0]}, 64'h0);
    end

    // Random traffic across all parameter corners
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      operation = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                              : 4'($urandom_range(6, 13));
      a = {$urandom, $urandom};
      b = ($urandom_range(0, 7) == 0) ? a : {$urandom, $urandom};
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
